// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Exhaustively sweeps the 16 input combinations of a 4-input
//               combinational circuit, captures its response and compares it
//               against a golden truth table.
//
//   Parameters
//     SETTLE         cycles each vector is held before sampling (1..15)
//     EXPECTED       golden truth table, bit i = expected output for vector i
//
//   Ports
//     clk            rising-edge clock
//     reset          synchronous active-high reset
//     start          request a sweep (honoured only while idle)
//     saida          response of the circuit under test
//     a,b,c,d        registered stimulus, a = MSB .. d = LSB of vector index
//     busy           sweep in progress
//     done           one-cycle pulse when a sweep completes
//     truth_table    captured response, bit i = saida sampled for vector i
//     mismatch_count number of vectors differing from EXPECTED (0..16)
//     first_fail     lowest mismatching vector (valid when mismatch_count != 0)
//     pass           last completed sweep had no mismatches
//
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'h7EE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        saida,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_count,
    output logic [3:0]  first_fail,
    output logic        pass
);

    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] C_LAST_VEC    = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_vec;
    logic [3:0]  r_cnt;
    logic        r_done;
    logic [15:0] r_table;
    logic [4:0]  r_mismatch;
    logic [3:0]  r_first_fail;
    logic        r_pass;
    logic        w_miss;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_DRIVE;
            S_DRIVE:  if (r_cnt == C_SETTLE_LAST) w_next = S_SAMPLE;
            S_SAMPLE: w_next = (r_vec == C_LAST_VEC) ? S_DONE : S_DRIVE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_miss = (saida != EXPECTED[r_vec]);

    // ------------------------------------------------------------------
    // Datapath: stimulus vector, settle counter and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vec        <= 4'd0;
            r_cnt        <= 4'd0;
            r_done       <= 1'b0;
            r_table      <= 16'd0;
            r_mismatch   <= 5'd0;
            r_first_fail <= 4'd0;
            r_pass       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec        <= 4'd0;
                        r_cnt        <= 4'd0;
                        r_table      <= 16'd0;
                        r_mismatch   <= 5'd0;
                        r_first_fail <= 4'd0;
                        r_pass       <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    r_table[r_vec] <= saida;
                    if (w_miss) begin
                        r_mismatch <= r_mismatch + 5'd1;
                        // A zero count means no earlier vector failed.
                        if (r_mismatch == 5'd0) r_first_fail <= r_vec;
                    end
                    // Vector 15 is held after the sweep; no wrap to 0.
                    if (r_vec != C_LAST_VEC) begin
                        r_vec <= r_vec + 4'd1;
                        r_cnt <= 4'd0;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_pass <= (r_mismatch == 5'd0);
                end
                default: ;
            endcase
        end
    end

    assign {a, b, c, d}   = r_vec;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign truth_table    = r_table;
    assign mismatch_count = r_mismatch;
    assign first_fail     = r_first_fail;
    assign pass           = r_pass;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Directed self-checking bench for truth_table_sweeper. Two
//               instances (SETTLE=1 and SETTLE=3) each drive a behavioural
//               4-input circuit whose behaviour is selected by a mode value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start1, start3;
    int   mode1, mode3;

    logic a1, b1, c1, d1, busy1, done1, pass1, saida1;
    logic a3, b3, c3, d3, busy3, done3, pass3, saida3;
    logic [15:0] tt1, tt3;
    logic [4:0]  mc1, mc3;
    logic [3:0]  ff1, ff3;
    logic [3:0]  v1, v3;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    // mode 0: correct circuit (7EE0); mode 1: output stuck at 0;
    // mode 2: correct except vector 1111 outputs 1.
    function automatic logic model(input int mode, input logic [3:0] v);
        logic [15:0] g;
        g = 16'h7EE0;
        case (mode)
            0:       return g[v];
            1:       return 1'b0;
            default: return (v == 4'hF) ? 1'b1 : g[v];
        endcase
    endfunction

    assign v1 = {a1, b1, c1, d1};
    assign v3 = {a3, b3, c3, d3};
    always_comb saida1 = model(mode1, v1);
    always_comb saida3 = model(mode3, v3);

    truth_table_sweeper #(.SETTLE(1), .EXPECTED(16'h7EE0)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .saida(saida1),
        .a(a1), .b(b1), .c(c1), .d(d1), .busy(busy1), .done(done1),
        .truth_table(tt1), .mismatch_count(mc1), .first_fail(ff1), .pass(pass1)
    );

    truth_table_sweeper #(.SETTLE(3), .EXPECTED(16'h7EE0)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .saida(saida3),
        .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
        .truth_table(tt3), .mismatch_count(mc3), .first_fail(ff3), .pass(pass3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start on the chosen instance and count edges until done.
    // On the SETTLE=3 instance, also verify vector hold time and inject
    // start pulses while busy (including during DONE).
    task automatic sweep(input bit use3, output int edges, output int stab_err);
        edges    = -1;
        stab_err = 0;
        if (use3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
        if (use3 && v3 != 4'd0) stab_err++;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (use3) begin
                if (n < 64 && v3 != 4'(n / 4)) stab_err++;
                start3 = (n == 10 || n == 40 || n == 64);
                if (done3) begin edges = n; break; end
            end else begin
                if (done1) begin edges = n; break; end
            end
        end
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    initial begin
        int e, s, dcount;
        bit hit;
        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        mode1  = 0;
        mode3  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_abcd",  32'(v1), 32'h0);
        check("reset_busy",  32'(busy1), 32'h0);
        check("reset_done",  32'(done1), 32'h0);
        check("reset_table", 32'(tt1), 32'h0);
        check("reset_mc",    32'(mc1), 32'h0);
        check("reset_pass",  32'(pass1), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Correct circuit, SETTLE=1
        mode1 = 0;
        sweep(1'b0, e, s);
        check("s1_done_edge", 32'(e), 32'd33);
        check("s1_busy_at_done", 32'(busy1), 32'h0);
        check("s1_table", 32'(tt1), 32'h7EE0);
        check("s1_mc", 32'(mc1), 32'd0);
        check("s1_pass", 32'(pass1), 32'h1);
        @(posedge clk); #1;
        check("s1_done_one_cycle", 32'(done1), 32'h0);
        check("s1_abcd_hold", 32'(v1), 32'hF);
        repeat (5) @(posedge clk);
        #1;
        check("s1_table_hold", 32'(tt1), 32'h7EE0);
        check("s1_pass_hold", 32'(pass1), 32'h1);

        // Output stuck at 0
        mode1 = 1;
        sweep(1'b0, e, s);
        check("zero_done_edge", 32'(e), 32'd33);
        check("zero_table", 32'(tt1), 32'h0000);
        check("zero_mc", 32'(mc1), 32'd9);
        check("zero_ff", 32'(ff1), 32'd5);
        check("zero_pass", 32'(pass1), 32'h0);

        // Only vector 1111 wrong
        mode1 = 2;
        sweep(1'b0, e, s);
        check("v15_table", 32'(tt1), 32'hFEE0);
        check("v15_mc", 32'(mc1), 32'd1);
        check("v15_ff", 32'(ff1), 32'd15);
        check("v15_pass", 32'(pass1), 32'h0);

        // Back-to-back: correct circuit after a failing sweep
        mode1 = 0;
        sweep(1'b0, e, s);
        check("b2b_table", 32'(tt1), 32'h7EE0);
        check("b2b_mc", 32'(mc1), 32'd0);
        check("b2b_ff", 32'(ff1), 32'd0);
        check("b2b_pass", 32'(pass1), 32'h1);

        // SETTLE=3 with ignored mid-sweep start pulses
        mode3 = 0;
        sweep(1'b1, e, s);
        check("s3_done_edge", 32'(e), 32'd65);
        check("s3_vector_hold", 32'(s), 32'd0);
        check("s3_table", 32'(tt3), 32'h7EE0);
        check("s3_pass", 32'(pass3), 32'h1);
        @(posedge clk); #1;
        check("s3_no_restart", 32'(busy3), 32'h0);

        // Reset while vector 7 is driven
        mode1  = 1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (v1 == 4'd7) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        check("rst_reached_v7", 32'(hit), 32'h1);
        check("rst_busy_v7", 32'(busy1), 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_abcd", 32'(v1), 32'h0);
        check("rst_busy", 32'(busy1), 32'h0);
        check("rst_done", 32'(done1), 32'h0);
        check("rst_table", 32'(tt1), 32'h0);
        check("rst_mc", 32'(mc1), 32'd0);
        check("rst_ff", 32'(ff1), 32'd0);
        check("rst_pass", 32'(pass1), 32'h0);
        dcount = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done1 || busy1) dcount++;
        end
        check("rst_no_done", 32'(dcount), 32'd0);
        mode1 = 0;
        sweep(1'b0, e, s);
        check("rst_resweep_edge", 32'(e), 32'd33);
        check("rst_resweep_table", 32'(tt1), 32'h7EE0);
        check("rst_resweep_pass", 32'(pass1), 32'h1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE, 1, DUT settle cycles per vector before sampling; legal range 1..15.
REQ-002 Parameter EXPECTED, 16'h7EE0, golden truth table of the 4-input circuit; bit i = expected output for vector i.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a full sweep; sampled only in IDLE.
REQ-006 saida  input  1  output of the circuit under test, driven by a,b,c,d.
REQ-007 a, b, c, d  output  1 each  registered stimulus to the circuit under test; a = MSB, d = LSB of vector index.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse at sweep completion.
REQ-010 table  output  16  captured truth table; bit i = saida sampled for vector i.
REQ-011 mismatch_count  output  5  number of vectors where captured bit differs from EXPECTED (0..16).
REQ-012 first_fail  output  4  lowest vector index that mismatched; valid only when mismatch_count != 0.
REQ-013 pass  output  1  high when last completed sweep had mismatch_count == 0.

Function
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, DONE; encoding is free.
REQ-015 IDLE: busy=0; on start=1 -> DRIVE, vector=0, settle counter=0, table/mismatch_count/first_fail/pass cleared.
REQ-016 DRIVE: {a,b,c,d}=vector held stable; counter increments each cycle; when counter == SETTLE-1 -> SAMPLE.
REQ-017 SAMPLE: table[vector] <= saida; if saida != EXPECTED[vector], mismatch_count += 1, and first_fail <= vector if this is the first mismatch of the sweep.
REQ-018 SAMPLE with vector != 15: vector += 1, counter=0, -> DRIVE; vector == 15: -> DONE, no wrap to 0.
REQ-019 Vectors swept strictly ascending 0000..1111; each vector occupies exactly SETTLE+1 cycles (SETTLE in DRIVE, 1 in SAMPLE).
REQ-020 DONE: done=1 for exactly one cycle, pass <= (mismatch_count == 0), -> IDLE.
REQ-021 busy=1 in DRIVE, SAMPLE and DONE; 0 in IDLE.
REQ-022 Latency: start sampled at edge 0 -> done high after edge 16*(SETTLE+1)+1, i.e. 33 edges for SETTLE=1.
REQ-023 start while busy (DRIVE/SAMPLE/DONE) is ignored; no restart, no queueing.
REQ-024 table, mismatch_count, first_fail, pass hold their values in IDLE until the next accepted start.
REQ-025 a,b,c,d hold the last driven vector (1111) in IDLE after a sweep; 0000 after reset.
REQ-026 mismatch_count saturates by construction at 16; no overflow for the 5-bit width.

Reset
REQ-027 reset=1 at a rising edge forces IDLE, a=b=c=d=0, busy=0, done=0, table=0, mismatch_count=0, first_fail=0, pass=0, counters=0.
REQ-028 reset wins over start in the same cycle; reset mid-sweep aborts with no done pulse and discards partial results.

Verification
REQ-029 Correct DUT model, SETTLE=1, start pulse -> done at edge 33, table=16'h7EE0, mismatch_count=0, pass=1.
REQ-030 saida tied 0 -> table=16'h0000, mismatch_count=9, first_fail=5, pass=0.
REQ-031 DUT model with vector 1111 output 1 -> table=16'hFEE0, mismatch_count=1, first_fail=15, pass=0.
REQ-032 SETTLE=3, correct DUT -> done at edge 65; each a,b,c,d value stable 4 cycles; start pulses mid-sweep ignored.
REQ-033 reset asserted while vector=7 -> next cycle all outputs at reset values, no done; new start then completes normally.
REQ-034 Two back-to-back sweeps (failing then correct DUT) -> second sweep reports mismatch_count=0, pass=1, stats fully cleared.
